buzzer_seq: RTL and testbench
=============================

BUZZER_SEQ -- requirements
Module: buzzer_seq

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, note-queue depth (power of two, 2..16).
REQ-002 SHALL have parameter TICK_DIV, default 50000, clk cycles per duration tick (1 ms at 50 MHz).
REQ-003 SHALL have parameter HW_VER, default 32'h01, value returned at ADDR_VER.
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port wr  input  1  CPU write strobe, one write per cycle high.
REQ-007 SHALL have port waddr  input  32  CPU write address.
REQ-008 SHALL have port wdata  input  32  CPU write data.
REQ-009 SHALL have port rd  input  1  CPU read strobe.
REQ-010 SHALL have port raddr  input  32  CPU read address.
REQ-011 SHALL have port rdata  output  32  read data, registered.
REQ-012 SHALL have port buzzer_pin  output  1  square-wave drive to buzzer.
REQ-013 SHALL have port busy  output  1  high while a note is playing.
REQ-014 SHALL have port irq  output  1  level interrupt: queue empty and idle, gated by CTRL.ie.

Function
REQ-015 SHALL decode ADDR_VER=0x0 (RO), ADDR_CTRL=0x4 (RW), ADDR_NOTE=0x8 (WO push), ADDR_STATUS=0xC (RO); unmapped reads return 0, unmapped writes ignored.
REQ-016 SHALL implement CTRL: bit0 en, bit1 ie; bit2 flush, bit3 ovf_clr (self-clearing, read as 0).
REQ-017 SHALL implement NOTE word: [15:0] half_period in clk cycles, [31:16] duration in ticks.
REQ-018 SHALL implement STATUS: [4:0] count, [8] empty, [9] full, [10] busy, [11] ovf (sticky).
REQ-019 SHALL return rdata one cycle after rd; rdata otherwise holds its last value.
REQ-020 SHALL push a write to ADDR_NOTE when not full; when full, drop the write and set ovf.
REQ-021 SHALL, on simultaneous push and pop, leave count unchanged and accept the push even when full.
REQ-022 SHALL use FSM states IDLE, LOAD, PLAY.
REQ-023 IDLE->LOAD when en=1 and queue not empty; LOAD pops head into current-note registers in one cycle.
REQ-024 LOAD->PLAY when duration!=0; when duration==0, discard the note and go LOAD (queue not empty) or IDLE (empty).
REQ-025 In PLAY, buzzer_pin SHALL toggle every half_period clk cycles, starting low; half_period==0 is a rest (pin held low).
REQ-026 A free-running tick prescaler, reset to 0 on entry to PLAY, SHALL decrement the remaining duration once per TICK_DIV cycles.
REQ-027 PLAY SHALL end on the cycle remaining duration reaches 0: pin low, then go LOAD (queue not empty, en=1) or IDLE; no gap cycles beyond LOAD.
REQ-028 en cleared mid-note SHALL abort to IDLE next cycle with pin low; queued notes are retained.
REQ-029 flush SHALL empty the queue and abort any note to IDLE in the same cycle; flush wins over a same-cycle push.
REQ-030 busy SHALL equal (state==PLAY); irq SHALL equal ie & empty & (state==IDLE).
REQ-031 All counters SHALL be unsigned and sized for their maxima, with no wrap in normal operation.

Reset
REQ-032 On rstn low: FSM IDLE, queue empty, CTRL=0, ovf=0, rdata=0, buzzer_pin=0, busy=0, irq=0, all counters 0.
REQ-033 Reset asserted mid-note SHALL drive buzzer_pin low immediately, asynchronously.

Structure
REQ-034 Register addresses, CTRL/STATUS bit positions and FSM state encoding SHALL live in shared package buzzer_pkg.
REQ-035 Note queue SHALL be one sub-module, sync_fifo (width 32, depth FIFO_DEPTH, count/full/empty outputs).

Verification
REQ-036 Push {dur=2, hp=4}, en=1, TICK_DIV=10 -> pin toggles every 4 cycles for 20 cycles, busy high 20 cycles, then IDLE and irq=1 with ie=1.
REQ-037 Push 9 notes with en=0, depth 8 -> STATUS count=8, full=1, ovf=1; ovf_clr -> ovf=0.
REQ-038 Queue {dur=1, hp=0} then {dur=1, hp=3} -> pin low for 1 tick, then toggles every 3 cycles; exactly one LOAD cycle between notes.
REQ-039 Push {dur=0} then {dur=1, hp=2} -> first note skipped, busy never asserted for it.
REQ-040 Clear en mid-note with 3 notes queued -> IDLE next cycle, pin=0, count=2.
REQ-041 Assert rstn low mid-note -> pin=0 immediately; after release, STATUS reads 0x100 (empty only) and rdata=0 before the first read.

Source files
------------

// File: rtl/buzzer_pkg.sv
`default_nettype none
// buzzer_pkg: register map, CTRL/STATUS bit positions, note layout and FSM encoding for buzzer_seq.
// Revision 1.0
package buzzer_pkg;

  localparam logic [31:0] ADDR_VER    = 32'h0000_0000;
  localparam logic [31:0] ADDR_CTRL   = 32'h0000_0004;
  localparam logic [31:0] ADDR_NOTE   = 32'h0000_0008;
  localparam logic [31:0] ADDR_STATUS = 32'h0000_000C;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_IE      = 1;
  localparam int CTRL_FLUSH   = 2;
  localparam int CTRL_OVF_CLR = 3;

  localparam int STAT_EMPTY = 8;
  localparam int STAT_FULL  = 9;
  localparam int STAT_BUSY  = 10;
  localparam int STAT_OVF   = 11;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] PLAY = 2'd2;

  typedef struct packed {
    logic [15:0] dur;
    logic [15:0] half_period;
  } note_t;

  function automatic logic [31:0] status_word(
    input logic [4:0] count,
    input logic       empty,
    input logic       full,
    input logic       busy,
    input logic       ovf
  );
    logic [31:0] w;
    w             = '0;
    w[4:0]        = count;
    w[STAT_EMPTY] = empty;
    w[STAT_FULL]  = full;
    w[STAT_BUSY]  = busy;
    w[STAT_OVF]   = ovf;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// sync_fifo: show-ahead synchronous FIFO with flush; a push into a full queue is taken only with a same-cycle pop.
// Revision 1.0
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic             w_push;
  logic             w_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

  assign w_pop  = pop_i && !empty_o;
  assign w_push = push_i && (!full_o || w_pop);

  always_ff @(posedge clk) begin
    if (w_push && !flush_i) begin
      mem_q[wptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (w_push) wptr_q <= wptr_q + AW'(1);
      if (w_pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/buzzer_seq.sv
`default_nettype none
// buzzer_seq: CPU-programmed note queue driving a square-wave buzzer (IDLE/LOAD/PLAY sequencer).
// Revision 1.0
module buzzer_seq
  import buzzer_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter int          TICK_DIV   = 50000,
  parameter logic [31:0] HW_VER     = 32'h01
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        wr,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  input  logic        rd,
  input  logic [31:0] raddr,
  output logic [31:0] rdata,
  output logic        buzzer_pin,
  output logic        busy,
  output logic        irq
);

  localparam int             CW        = $clog2(FIFO_DEPTH) + 1;
  localparam int             PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  TICK_LAST = PW'(TICK_DIV - 1);

  logic [1:0]    state_q, state_d;
  logic [15:0]   cur_hp_q, cur_hp_d;
  logic [15:0]   dur_q, dur_d;
  logic [15:0]   hp_cnt_q, hp_cnt_d;
  logic [PW-1:0] tick_q, tick_d;
  logic          pin_q, pin_d;
  logic          en_q, ie_q, ovf_q, ovf_d;
  logic [31:0]   rdata_q;

  logic          w_ctrl_wr, w_note_wr, w_flush, w_ovf_clr, w_en, w_pop;
  logic [31:0]   w_head_raw, w_rd_val;
  note_t         w_head;
  logic [CW-1:0] w_count;
  logic          w_full, w_empty;

  assign w_ctrl_wr = wr && (waddr == ADDR_CTRL);
  assign w_note_wr = wr && (waddr == ADDR_NOTE);
  assign w_flush   = w_ctrl_wr && wdata[CTRL_FLUSH];
  assign w_ovf_clr = w_ctrl_wr && wdata[CTRL_OVF_CLR];
  // Sequencer decisions see a same-cycle CTRL write so an en clear aborts at the very next edge.
  assign w_en      = w_ctrl_wr ? wdata[CTRL_EN] : en_q;
  assign w_head    = note_t'(w_head_raw);

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_queue (
    .clk         (clk),
    .rstn        (rstn),
    .flush_i     (w_flush),
    .push_i      (w_note_wr),
    .push_data_i (wdata),
    .pop_i       (w_pop),
    .head_o      (w_head_raw),
    .count_o     (w_count),
    .full_o      (w_full),
    .empty_o     (w_empty)
  );

  always_comb begin
    state_d  = state_q;
    cur_hp_d = cur_hp_q;
    dur_d    = dur_q;
    hp_cnt_d = hp_cnt_q;
    tick_d   = tick_q;
    pin_d    = 1'b0;
    w_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_en && !w_empty) state_d = LOAD;
      end
      LOAD: begin
        w_pop    = 1'b1;
        cur_hp_d = w_head.half_period;
        dur_d    = w_head.dur;
        hp_cnt_d = '0;
        tick_d   = '0;
        if (w_head.dur != '0)                    state_d = PLAY;
        else if (w_en && (w_count > CW'(1)))     state_d = LOAD;
        else                                     state_d = IDLE;
      end
      PLAY: begin
        if (!w_en) begin
          state_d = IDLE;
        end else begin
          pin_d = pin_q;
          if (cur_hp_q != '0) begin
            if (hp_cnt_q == cur_hp_q - 16'd1) begin
              hp_cnt_d = '0;
              pin_d    = ~pin_q;
            end else begin
              hp_cnt_d = hp_cnt_q + 16'd1;
            end
          end
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            dur_d  = dur_q - 16'd1;
            if (dur_q == 16'd1) begin
              pin_d   = 1'b0;
              state_d = w_empty ? IDLE : LOAD;
            end
          end else begin
            tick_d = tick_q + PW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (w_flush) begin
      state_d = IDLE;
      pin_d   = 1'b0;
      w_pop   = 1'b0;
    end
  end

  // A push dropped only if the queue stays full, i.e. no pop in the same cycle.
  assign ovf_d = (w_note_wr && w_full && !w_pop) || (ovf_q && !w_ovf_clr);

  always_comb begin
    w_rd_val = '0;
    case (raddr)
      ADDR_VER:    w_rd_val = HW_VER;
      ADDR_CTRL:   w_rd_val = {30'd0, ie_q, en_q};
      ADDR_STATUS: w_rd_val = status_word(5'(w_count), w_empty, w_full, busy, ovf_q);
      default:     w_rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cur_hp_q <= '0;
      dur_q    <= '0;
      hp_cnt_q <= '0;
      tick_q   <= '0;
      pin_q    <= 1'b0;
      en_q     <= 1'b0;
      ie_q     <= 1'b0;
      ovf_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cur_hp_q <= cur_hp_d;
      dur_q    <= dur_d;
      hp_cnt_q <= hp_cnt_d;
      tick_q   <= tick_d;
      pin_q    <= pin_d;
      en_q     <= w_en;
      ovf_q    <= ovf_d;
      if (w_ctrl_wr) ie_q <= wdata[CTRL_IE];
      if (rd)        rdata_q <= w_rd_val;
    end
  end

  assign rdata      = rdata_q;
  assign buzzer_pin = pin_q;
  assign busy       = (state_q == PLAY);
  assign irq        = ie_q && w_empty && (state_q == IDLE);

endmodule
`default_nettype wire

// File: tb/tb_buzzer_seq.sv
`default_nettype none
// tb_buzzer_seq: directed and randomized note sequences checked by a note-level reference model and scoreboard.
// Revision 1.0
module tb_buzzer_seq;

  localparam int          DEPTH = 8;
  localparam int          TDIV  = 10;
  localparam logic [31:0] VER   = 32'h0000_00A5;
  localparam logic [31:0] A_VER = 32'h0, A_CTRL = 32'h4, A_NOTE = 32'h8, A_STAT = 32'hC;

  logic        clk = 1'b0, rstn = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [31:0] waddr = '0, wdata = '0, raddr = '0;
  logic [31:0] rdata;
  logic        buzzer_pin, busy, irq;

  int tests = 0;
  int fails = 0;

  typedef struct { int hp; int dur; int gap; } exp_note_t;
  exp_note_t   exp_q[$];
  exp_note_t   cur_e;
  logic [31:0] exp_rd[$];
  string       exp_nm[$];
  logic [31:0] mq[$];
  bit          m_ovf = 1'b0;
  bit          mon_abort = 1'b0;
  int          idle_pin_err = 0;

  always #5 clk = ~clk;

  buzzer_seq #(
    .FIFO_DEPTH (DEPTH),
    .TICK_DIV   (TDIV),
    .HW_VER     (VER)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .wr         (wr),
    .waddr      (waddr),
    .wdata      (wdata),
    .rd         (rd),
    .raddr      (raddr),
    .rdata      (rdata),
    .buzzer_pin (buzzer_pin),
    .busy       (busy),
    .irq        (irq)
  );

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endfunction

  function automatic logic exp_pin(input int hp, input int k);
    if (hp == 0) return 1'b0;
    return ((k / hp) % 2) == 1;
  endfunction

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s       = 32'(mq.size());
    s[8]    = (mq.size() == 0);
    s[9]    = (mq.size() == DEPTH);
    s[11]   = m_ovf;
    return s;
  endfunction

  // Read scoreboard: rdata is due one cycle after the strobe.
  logic rd_d1 = 1'b0;
  always @(posedge clk) rd_d1 <= rd;
  always @(negedge clk) begin
    if (rd_d1) begin
      if (exp_rd.size() == 0) begin
        tests++; fails++;
        $display("FAIL rd_unexpected: rdata 0x%08h with no read outstanding", rdata);
      end else begin
        check(exp_nm.pop_front(), rdata, exp_rd.pop_front());
      end
    end
  end

  // Note monitor: each busy interval is matched against the next expected note.
  bit   in_note = 1'b0, have_exp = 1'b0, wave_bad = 1'b0;
  int   k = 0, gap = 0, bad_k = 0;
  logic bad_pin = 1'b0;
  always @(negedge clk) begin
    if (busy) begin
      if (!in_note) begin
        in_note = 1'b1; k = 0; wave_bad = 1'b0;
        if (exp_q.size() == 0) begin
          tests++; fails++; have_exp = 1'b0;
          $display("FAIL note_start: busy=1 with no note expected, required busy=0");
        end else begin
          cur_e = exp_q.pop_front(); have_exp = 1'b1;
          if (cur_e.gap >= 0) check("note_gap", gap, cur_e.gap);
        end
      end
      if (have_exp && !wave_bad && (buzzer_pin !== exp_pin(cur_e.hp, k))) begin
        wave_bad = 1'b1; bad_k = k; bad_pin = buzzer_pin;
      end
      k++;
    end else begin
      if (buzzer_pin !== 1'b0) idle_pin_err++;
      if (in_note) begin
        in_note = 1'b0; gap = 0;
        if (have_exp) begin
          tests++;
          if (wave_bad) begin
            fails++;
            $display("FAIL note_wave: hp=%0d cycle %0d pin=%b, required %b", cur_e.hp, bad_k, bad_pin, ~bad_pin);
          end
          if (!mon_abort) check("note_len", k, cur_e.dur * TDIV);
        end
        mon_abort = 1'b0;
      end
      gap++;
    end
  end

  task automatic cpu_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk); wr = 1'b1; waddr = a; wdata = d;
    @(negedge clk); wr = 1'b0;
  endtask

  task automatic cpu_rd(input logic [31:0] a, input logic [31:0] expv, input string nm);
    @(negedge clk); rd = 1'b1; raddr = a;
    exp_rd.push_back(expv); exp_nm.push_back(nm);
    @(negedge clk); rd = 1'b0;
  endtask

  task automatic push_note(input int dur, input int hp);
    logic [31:0] w;
    w = {dur[15:0], hp[15:0]};
    cpu_wr(A_NOTE, w);
    if (mq.size() < DEPTH) mq.push_back(w);
    else m_ovf = 1'b1;
  endtask

  // Turn the model queue into the notes expected to sound, with the LOAD gap before each.
  task automatic enable_play();
    int zeros, d, h;
    bit first;
    zeros = 0; first = 1'b1;
    foreach (mq[i]) begin
      d = int'(mq[i][31:16]); h = int'(mq[i][15:0]);
      if (d == 0) zeros++;
      else begin
        exp_q.push_back('{h, d, first ? -1 : 1 + zeros});
        first = 1'b0; zeros = 0;
      end
    end
    mq.delete();
    cpu_wr(A_CTRL, 32'h3);
  endtask

  task automatic wait_sig(input int which, input int maxc, input string nm);
    int c;
    logic v;
    c = 0;
    v = (which == 0) ? irq : (which == 1) ? busy : buzzer_pin;
    while (v !== 1'b1 && c < maxc) begin
      @(negedge clk); c++;
      v = (which == 0) ? irq : (which == 1) ? busy : buzzer_pin;
    end
    tests++;
    if (v !== 1'b1) begin
      fails++;
      $display("FAIL %s: still 0 after %0d cycles, required 1", nm, c);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_pin", {31'd0, buzzer_pin}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    cpu_rd(A_STAT, 32'h100, "rst_status");
    cpu_rd(A_VER, VER, "ver");
    cpu_rd(A_CTRL, 32'h0, "rst_ctrl");
    cpu_rd(32'h10, 32'h0, "unmapped");
    cpu_rd(A_NOTE, 32'h0, "note_wo");

    // Basic note, then irq with ie.
    push_note(2, 4);
    enable_play();
    cpu_rd(A_CTRL, 32'h3, "ctrl_rb");
    wait_sig(0, 200, "irq_after_note");
    cpu_rd(A_STAT, 32'h100, "stat_after_note");
    cpu_wr(A_CTRL, 32'h0);

    // Overflow, sticky ovf, ovf_clr, flush.
    for (int i = 0; i < 9; i++) push_note(1, 2);
    cpu_rd(A_STAT, model_status(), "stat_ovf");
    cpu_wr(A_CTRL, 32'h8); m_ovf = 1'b0;
    cpu_rd(A_STAT, model_status(), "stat_ovf_clr");
    cpu_wr(A_CTRL, 32'h4); mq.delete();
    cpu_rd(A_STAT, 32'h100, "stat_flush");

    // Rest then tone; zero-length note skipped.
    push_note(1, 0); push_note(1, 3);
    enable_play();
    wait_sig(0, 200, "irq_rest_tone");
    cpu_wr(A_CTRL, 32'h0);
    push_note(0, 5); push_note(1, 2);
    enable_play();
    wait_sig(0, 200, "irq_skip");
    cpu_wr(A_CTRL, 32'h0);

    // Randomized rounds.
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++)
        push_note(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 3), $urandom_range(0, 7));
      cpu_rd(A_STAT, model_status(), "rand_stat_queued");
      enable_play();
      wait_sig(0, 40 * n + 50, "rand_irq");
      cpu_rd(A_STAT, model_status(), "rand_stat_done");
      cpu_wr(A_CTRL, 32'h8); m_ovf = 1'b0;
    end

    // en cleared mid-note with three queued.
    for (int i = 0; i < 3; i++) push_note(3, 2);
    exp_q.push_back('{2, 3, -1}); void'(mq.pop_front());
    cpu_wr(A_CTRL, 32'h1);
    wait_sig(1, 20, "abort_busy");
    repeat (5) @(negedge clk);
    mon_abort = 1'b1;
    cpu_wr(A_CTRL, 32'h0);
    check("abort_busy_low", {31'd0, busy}, 32'h0);
    check("abort_pin_low", {31'd0, buzzer_pin}, 32'h0);
    cpu_rd(A_STAT, model_status(), "abort_stat");
    cpu_wr(A_CTRL, 32'h4); mq.delete();
    cpu_rd(A_STAT, 32'h100, "abort_flush");

    // Asynchronous reset mid-note with pin high.
    push_note(3, 2);
    exp_q.push_back('{2, 3, -1}); void'(mq.pop_front());
    cpu_wr(A_CTRL, 32'h1);
    wait_sig(1, 20, "rst_mid_busy");
    wait_sig(2, 20, "rst_mid_pin_high");
    #2;
    mon_abort = 1'b1;
    rstn = 1'b0;
    #1;
    check("async_rst_pin", {31'd0, buzzer_pin}, 32'h0);
    check("async_rst_busy", {31'd0, busy}, 32'h0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    mq.delete(); m_ovf = 1'b0;
    check("rst2_rdata", rdata, 32'h0);
    cpu_rd(A_STAT, 32'h100, "rst2_status");
    cpu_rd(A_CTRL, 32'h0, "rst2_ctrl");

    repeat (3) @(negedge clk);
    check("notes_unplayed", exp_q.size(), 0);
    check("reads_outstanding", exp_rd.size(), 0);
    check("idle_pin_high", idle_pin_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
